// File: rtl/mem_pkg.sv
// Shared constants for the CPU-side memory responder: FSM encodings and parameter defaults.
package mem_pkg;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam int unsigned PROG_BASE_DEF  = 8;
  localparam int unsigned INIT_VALUE_DEF = 0;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_WIDTH storage with one write port and a registered, read-first read port.
module mem_array #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the clear sweep initialises them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-edge write and read return the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/memory.sv
// CPU memory responder: post-reset clear sweep, optional boot loader, then 1-cycle-latency RAM.
// Boot loader ports and LOAD state exist only when MEM_BOOT_LOAD_EN is defined.
module memory
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned INIT_VALUE = INIT_VALUE_DEF
`ifdef MEM_BOOT_LOAD_EN
  ,
  parameter int unsigned PROG_BASE  = PROG_BASE_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] mem_in,
  output logic                  ready
`ifdef MEM_BOOT_LOAD_EN
  ,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_done
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  logic [1:0]            state, state_nx;
  logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_nx;
  logic                  wr_en_c, rd_en_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
`ifdef MEM_BOOT_LOAD_EN
  logic [ADDR_WIDTH-1:0] load_addr, load_addr_nx;
`endif

  // State, counters and the ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_addr  <= '0;
      ready     <= 1'b0;
`ifdef MEM_BOOT_LOAD_EN
      load_addr <= ADDR_WIDTH'(PROG_BASE);
`endif
    end else begin
      state     <= state_nx;
      clr_addr  <= clr_addr_nx;
      ready     <= (state_nx == ST_RUN);
`ifdef MEM_BOOT_LOAD_EN
      load_addr <= load_addr_nx;
`endif
    end
  end

  // Next state and write-port mux: sweep, loader or CPU depending on phase.
  always_comb begin
    state_nx     = state;
    clr_addr_nx  = clr_addr;
    wr_en_c      = 1'b0;
    wr_addr_c    = mem_addr;
    wr_data_c    = mem_data;
    rd_en_c      = 1'b0;
`ifdef MEM_BOOT_LOAD_EN
    load_addr_nx = load_addr;
`endif
    case (state)
      ST_CLEAR: begin
        wr_en_c     = 1'b1;
        wr_addr_c   = clr_addr;
        wr_data_c   = DATA_WIDTH'(INIT_VALUE);
        clr_addr_nx = clr_addr + ADDR_WIDTH'(1);
        if (clr_addr == ADDR_LAST) begin
`ifdef MEM_BOOT_LOAD_EN
          state_nx = ST_LOAD;
`else
          state_nx = ST_RUN;
`endif
        end
      end
`ifdef MEM_BOOT_LOAD_EN
      ST_LOAD: begin
        wr_en_c   = load_valid;
        wr_addr_c = load_addr;
        wr_data_c = load_data;
        if (load_valid) load_addr_nx = load_addr + ADDR_WIDTH'(1);
        // Loading stops at the top of the array rather than wrapping onto the sweep area.
        if (load_done || (load_valid && (load_addr == ADDR_LAST))) state_nx = ST_RUN;
      end
`endif
      ST_RUN: begin
        wr_en_c = mem_we;
        rd_en_c = 1'b1;
      end
      default: state_nx = ST_CLEAR;
    endcase
  end

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_c),
    .wr_addr (wr_addr_c),
    .wr_data (wr_data_c),
    .rd_en   (rd_en_c),
    .rd_addr (mem_addr),
    .rd_data (mem_in)
  );

endmodule
